// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, tile codes and the game-state bundle
// shared by the VGA frame sequencer and its sync counter.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [2:0] BDR = 3'd0;
    localparam logic [2:0] SKY = 3'd1;
    localparam logic [2:0] BLK = 3'd2;
    localparam logic [2:0] GND = 3'd3;
    localparam logic [2:0] TKN = 3'd4;
    localparam logic [2:0] CK1 = 3'd5;
    localparam logic [2:0] CK2 = 3'd6;

    localparam int SCREEN_WIDTH    = 640;
    localparam int SCREEN_HEIGHT   = 480;
    localparam int BLOCK_WIDTH     = 32;
    localparam int CHARACTER_WIDTH = 32;

    typedef struct packed {
        int mario_x;
        int mario_y;
        int goomba_x;
        int goomba_y;
        int goomba_2x;
        int goomba_2y;
        int number;
        int lives;
    } game_state_t;

    function automatic logic sync_level(input logic active, input logic in_pulse);
        return in_pulse ? active : ~active;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical pixel counters with sync and display-enable decode.
// Outputs are decoded straight from the counter registers (no pipeline).
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BACK      = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BACK      = vga_timing_pkg::V_BACK,
    parameter bit SYNC_ACTIVE = 1'b0,
    localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL)
) (
    input  logic          vga_clock,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          line_end,
    output logic          hsync,
    output logic          vsync,
    output logic          display_enable
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);

    // Sync windows use one extra bit so an end equal to the total still fits.
    localparam logic [HW:0] HS_START = (HW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [HW:0] HS_END   = (HW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW:0] VS_START = (VW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [VW:0] VS_END   = (VW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    if (!(H_TOTAL > H_VISIBLE && H_VISIBLE > 0)) begin : g_bad_h
        $error("vga_sync_counter: horizontal timing needs total > visible > 0");
    end
    if (!(V_TOTAL > V_VISIBLE && V_VISIBLE > 0)) begin : g_bad_v
        $error("vga_sync_counter: vertical timing needs total > visible > 0");
    end

    logic          h_in_sync;
    logic          v_in_sync;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;

    assign line_end = (h_cnt == H_LAST);

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    assign h_in_sync = (h_ext >= HS_START) && (h_ext < HS_END);
    assign v_in_sync = (v_ext >= VS_START) && (v_ext < VS_END);

    assign hsync          = sync_level(SYNC_ACTIVE, h_in_sync);
    assign vsync          = sync_level(SYNC_ACTIVE, v_in_sync);
    assign display_enable = (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA timing plus tear-free game-state shadows latched at vblank start.
// Optional hearts blinking is enabled by defining VGA_HEARTS_BLINK_EN.
module vga_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BACK      = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BACK      = vga_timing_pkg::V_BACK,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int BLINK_LOG2  = 5
) (
    input  logic vga_clock,
    input  logic reset,
    input  int   mario_x,
    input  int   mario_y,
    input  int   goomba_x,
    input  int   goomba_y,
    input  int   goomba_2x,
    input  int   goomba_2y,
    input  int   number,
    input  int   lives,
    input  logic show_hearts_req,
    output logic hsync,
    output logic vsync,
    output int   row,
    output int   column,
    output logic display_enable,
    output logic frame_tick,
    output int   mario_x_s,
    output int   mario_y_s,
    output int   goomba_x_s,
    output int   goomba_y_s,
    output int   goomba_2x_s,
    output int   goomba_2y_s,
    output int   number_s,
    output int   lives_s,
    output logic show_hearts
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [VW-1:0] V_LAST_VIS = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] V_BLANK0   = VW'(V_VISIBLE);

    if (BLINK_LOG2 < 0 || BLINK_LOG2 > 30) begin : g_bad_blink
        $error("vga_frame_sequencer: BLINK_LOG2 out of range");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          line_end;
    logic          latch;
    logic          hearts_next;
    game_state_t   live;
    game_state_t   shadow;

    vga_sync_counter #(
        .H_VISIBLE   (H_VISIBLE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_VISIBLE   (V_VISIBLE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_sync (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .line_end       (line_end),
        .hsync          (hsync),
        .vsync          (vsync),
        .display_enable (display_enable)
    );

    assign column = 32'(h_cnt);
    assign row    = 32'(v_cnt);

    // Latch on the edge that leaves the last visible line.
    assign latch      = line_end && (v_cnt == V_LAST_VIS);
    assign frame_tick = (h_cnt == '0) && (v_cnt == V_BLANK0);

    assign live = '{
        mario_x:   mario_x,
        mario_y:   mario_y,
        goomba_x:  goomba_x,
        goomba_y:  goomba_y,
        goomba_2x: goomba_2x,
        goomba_2y: goomba_2y,
        number:    number,
        lives:     lives
    };

`ifdef VGA_HEARTS_BLINK_EN
    logic [BLINK_LOG2:0] frame_cnt;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (latch) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign hearts_next = show_hearts_req & frame_cnt[BLINK_LOG2];
`else
    assign hearts_next = show_hearts_req;
`endif

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            shadow      <= '0;
            show_hearts <= 1'b0;
        end else if (latch) begin
            shadow      <= live;
            show_hearts <= hearts_next;
        end
    end

    assign mario_x_s   = shadow.mario_x;
    assign mario_y_s   = shadow.mario_y;
    assign goomba_x_s  = shadow.goomba_x;
    assign goomba_y_s  = shadow.goomba_y;
    assign goomba_2x_s = shadow.goomba_2x;
    assign goomba_2y_s = shadow.goomba_2y;
    assign number_s    = shadow.number;
    assign lives_s     = shadow.lives;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Self-checking bench: a reduced-timing instance against an arithmetic model
// plus a default-timing instance for the real 640x480 line shape.
module tb_vga_frame_sequencer;

    localparam int HV = 24, HF = 4, HS = 6, HB = 6;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int L_POS = VV * HT - 1;
    localparam int BLINK = 1;
    localparam int DHT = 800;

    int checks = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   gin [8];
    logic req = 1'b0;

    logic s_hs, s_vs, s_de, s_tick, s_hearts;
    int   s_row, s_col;
    int   s_sh [8];
    logic d_hs, d_vs, d_de, d_tick, d_hearts;
    int   d_row, d_col;
    int   d_sh [8];

    string nm [8] = '{"mario_x_s", "mario_y_s", "goomba_x_s", "goomba_y_s",
                      "goomba_2x_s", "goomba_2y_s", "number_s", "lives_s"};

    always #20 clk = ~clk;

    vga_frame_sequencer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0), .BLINK_LOG2(BLINK)
    ) dut (
        .vga_clock(clk), .reset(rst),
        .mario_x(gin[0]), .mario_y(gin[1]), .goomba_x(gin[2]), .goomba_y(gin[3]),
        .goomba_2x(gin[4]), .goomba_2y(gin[5]), .number(gin[6]), .lives(gin[7]),
        .show_hearts_req(req),
        .hsync(s_hs), .vsync(s_vs), .row(s_row), .column(s_col),
        .display_enable(s_de), .frame_tick(s_tick),
        .mario_x_s(s_sh[0]), .mario_y_s(s_sh[1]), .goomba_x_s(s_sh[2]),
        .goomba_y_s(s_sh[3]), .goomba_2x_s(s_sh[4]), .goomba_2y_s(s_sh[5]),
        .number_s(s_sh[6]), .lives_s(s_sh[7]), .show_hearts(s_hearts)
    );

    vga_frame_sequencer dut_def (
        .vga_clock(clk), .reset(rst),
        .mario_x(gin[0]), .mario_y(gin[1]), .goomba_x(gin[2]), .goomba_y(gin[3]),
        .goomba_2x(gin[4]), .goomba_2y(gin[5]), .number(gin[6]), .lives(gin[7]),
        .show_hearts_req(req),
        .hsync(d_hs), .vsync(d_vs), .row(d_row), .column(d_col),
        .display_enable(d_de), .frame_tick(d_tick),
        .mario_x_s(d_sh[0]), .mario_y_s(d_sh[1]), .goomba_x_s(d_sh[2]),
        .goomba_y_s(d_sh[3]), .goomba_2x_s(d_sh[4]), .goomba_2y_s(d_sh[5]),
        .number_s(d_sh[6]), .lives_s(d_sh[7]), .show_hearts(d_hearts)
    );

    // Reference model: cycles since reset, plus shadows captured once per frame.
    int m_t;
    int m_lcount;
    int m_sh [8];
    bit m_hearts;
    int d_t;

    function automatic bit hearts_at(int k, bit r);
`ifdef VGA_HEARTS_BLINK_EN
        return r && (((k >> BLINK) & 1) == 1);
`else
        return r;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t <= 0;
            m_lcount <= 0;
            m_hearts <= 1'b0;
            for (int i = 0; i < 8; i++) m_sh[i] <= 0;
        end else begin
            if (m_t % FRAME == L_POS) begin
                for (int i = 0; i < 8; i++) m_sh[i] <= gin[i];
                m_hearts <= hearts_at(m_lcount, req);
                m_lcount <= m_lcount + 1;
            end
            m_t <= m_t + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) d_t <= 0;
        else d_t <= d_t + 1;
    end

    function automatic int e_h(int t);
        return (t % FRAME) % HT;
    endfunction

    function automatic int e_v(int t);
        return (t % FRAME) / HT;
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < 8; i++) gin[i] = int'($urandom);
        req = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            randomize_inputs();
        end
        @(negedge clk);
        checks++;
        if (s_row !== 0 || s_col !== 0) begin
            failures++;
            $display("FAIL reset_pos row=%0d col=%0d want 0 0", s_row, s_col);
        end
        checks++;
        if (s_de !== 1'b1 || s_hs !== 1'b1 || s_vs !== 1'b1 || s_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl de=%b hs=%b vs=%b tick=%b want 1 1 1 0",
                     s_de, s_hs, s_vs, s_tick);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (s_sh[i] !== 0) begin
                failures++;
                $display("FAIL reset_%s got %0d want 0", nm[i], s_sh[i]);
            end
        end
        checks++;
        if (s_hearts !== 1'b0 || d_de !== 1'b1 || d_hs !== 1'b1 || d_vs !== 1'b1) begin
            failures++;
            $display("FAIL reset_misc hearts=%b d_de=%b d_hs=%b d_vs=%b want 0 1 1 1",
                     s_hearts, d_de, d_hs, d_vs);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_tick();
        int n = 0;
        while (s_tick !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== VV * HT) begin
            failures++;
            $display("FAIL first_tick cycles=%0d want %0d", n, VV * HT);
        end
        @(negedge clk);
        checks++;
        if (s_tick !== 1'b0) begin
            failures++;
            $display("FAIL tick_width tick=%b want 0", s_tick);
        end
    endtask

    task automatic test_default_line();
        int lows = 0, first_low = -1, last_low = -1, de_fall = -1, n = 0;
        while (d_t % DHT != 0 && n < 2 * DHT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d_row !== d_t / DHT) begin
            failures++;
            $display("FAIL def_row got %0d want %0d", d_row, d_t / DHT);
        end
        for (int c = 0; c < DHT; c++) begin
            checks++;
            if (d_col !== d_t % DHT) begin
                failures++;
                $display("FAIL def_col got %0d want %0d", d_col, d_t % DHT);
            end
            if (d_hs === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = c;
                last_low = c;
            end
            if (d_de === 1'b0 && de_fall < 0) de_fall = c;
            @(negedge clk);
        end
        checks++;
        if (lows !== 96 || first_low !== 656 || last_low !== 751) begin
            failures++;
            $display("FAIL def_hsync low=%0d first=%0d last=%0d want 96 656 751",
                     lows, first_low, last_low);
        end
        checks++;
        if (de_fall !== 640) begin
            failures++;
            $display("FAIL def_de_fall col=%0d want 640", de_fall);
        end
    endtask

    task automatic test_random_frames();
        int h, v, last_tick = -1;
        bit e_de, e_hs, e_vs, e_tick;
        int vs_low_first = -1, vs_low_last = -1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            h = e_h(m_t);
            v = e_v(m_t);
            e_de = (h < HV) && (v < VV);
            e_hs = !(h >= HV + HF && h < HV + HF + HS);
            e_vs = !(v >= VV + VF && v < VV + VF + VS);
            e_tick = (h == 0) && (v == VV);
            checks++;
            if (s_col !== h || s_row !== v) begin
                failures++;
                $display("FAIL rnd_pos row=%0d col=%0d want %0d %0d", s_row, s_col, v, h);
            end
            checks++;
            if (s_de !== e_de || s_hs !== e_hs || s_vs !== e_vs || s_tick !== e_tick) begin
                failures++;
                $display("FAIL rnd_ctl de=%b hs=%b vs=%b tick=%b want %b %b %b %b",
                         s_de, s_hs, s_vs, s_tick, e_de, e_hs, e_vs, e_tick);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (s_sh[i] !== m_sh[i]) begin
                    failures++;
                    $display("FAIL rnd_%s got %0d want %0d", nm[i], s_sh[i], m_sh[i]);
                end
            end
            checks++;
            if (s_hearts !== m_hearts) begin
                failures++;
                $display("FAIL rnd_hearts got %b want %b", s_hearts, m_hearts);
            end
            if (s_vs === 1'b0 && c < FRAME + 2 * FRAME) begin
                if (vs_low_first < 0) vs_low_first = s_row;
                vs_low_last = s_row;
            end
            if (s_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (m_t - last_tick !== FRAME) begin
                        failures++;
                        $display("FAIL tick_period got %0d want %0d", m_t - last_tick, FRAME);
                    end
                end
                last_tick = m_t;
            end
            randomize_inputs();
        end
        checks++;
        if (vs_low_first !== VV + VF || vs_low_last !== VV + VF + VS - 1) begin
            failures++;
            $display("FAIL vsync_rows first=%0d last=%0d want %0d %0d",
                     vs_low_first, vs_low_last, VV + VF, VV + VF + VS - 1);
        end
    endtask

    task automatic test_hold();
        int n = 0;
        gin[0] = 100;
        @(negedge clk);
        while (s_tick !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (s_row !== 5 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_sh[0] !== 100) begin
            failures++;
            $display("FAIL hold_pre got %0d want 100", s_sh[0]);
        end
        gin[0] = 200;
        n = 0;
        while (s_row !== VV && n < 2 * FRAME) begin
            checks++;
            if (s_sh[0] !== 100) begin
                failures++;
                $display("FAIL hold_mid row=%0d got %0d want 100", s_row, s_sh[0]);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_sh[0] !== 200) begin
            failures++;
            $display("FAIL hold_post got %0d want 200", s_sh[0]);
        end
    endtask

    task automatic test_same_edge();
        int n = 0;
        while (m_t % FRAME != L_POS && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        gin[2] = 111;
        @(posedge clk);
        #1 gin[2] = 222;
        @(negedge clk);
        checks++;
        if (s_sh[2] !== 111 || s_tick !== 1'b1) begin
            failures++;
            $display("FAIL same_edge got %0d tick=%b want 111 1", s_sh[2], s_tick);
        end
        @(negedge clk);
        n = 0;
        while (s_tick !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_sh[2] !== 222) begin
            failures++;
            $display("FAIL same_edge_next got %0d want 222", s_sh[2]);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        for (int i = 0; i < 8; i++) gin[i] = 1000 + i;
        while (!(s_row === 7 && s_col === 13) && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_row !== 0 || s_col !== 0 || d_row !== 0 || d_col !== 0) begin
            failures++;
            $display("FAIL mid_reset_pos row=%0d col=%0d d_row=%0d d_col=%0d want 0",
                     s_row, s_col, d_row, d_col);
        end
        checks++;
        if (s_de !== 1'b1 || s_hs !== 1'b1 || s_vs !== 1'b1 || s_tick !== 1'b0 ||
            s_hearts !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ctl de=%b hs=%b vs=%b tick=%b hearts=%b want 1 1 1 0 0",
                     s_de, s_hs, s_vs, s_tick, s_hearts);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (s_sh[i] !== 0) begin
                failures++;
                $display("FAIL mid_reset_%s got %0d want 0", nm[i], s_sh[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (s_tick !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== VV * HT || s_sh[3] !== 1003) begin
            failures++;
            $display("FAIL restart tick_after=%0d goomba_y_s=%0d want %0d 1003",
                     n, s_sh[3], VV * HT);
        end
    endtask

    task automatic test_hearts();
        int n;
        bit e;
        req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (s_tick !== 1'b1 && n < 2 * FRAME) begin
                @(negedge clk);
                n++;
            end
`ifdef VGA_HEARTS_BLINK_EN
            e = (((m_lcount - 1) >> BLINK) & 1) == 1;
`else
            e = 1'b1;
`endif
            checks++;
            if (s_hearts !== e || n >= 2 * FRAME) begin
                failures++;
                $display("FAIL hearts frame=%0d got %b want %b", k, s_hearts, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) gin[i] = 0;
        test_reset();
        test_first_tick();
        test_default_line();
        test_random_frames();
        test_hold();
        test_same_edge();
        test_mid_reset();
        test_hearts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
